// File: rtl/uart_pkg.sv
// Shared UART types: parity mode, transmitter states and the parity helper.
package uart_pkg;

    typedef enum logic [1:0] {PAR_NONE, PAR_ODD, PAR_EVEN} parity_t;

    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;

    localparam int MAX_DATA_WIDTH = 9;

    // Unused upper bits must be zero so they do not disturb the XOR.
    function automatic logic parity_bit(input logic [MAX_DATA_WIDTH-1:0] data, input parity_t mode);
        return (^data) ^ (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with registered read data; pop_data holds the last popped word.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      level_reg;
    logic [WIDTH-1:0] pop_data_reg;
    logic             do_push;
    logic             do_pop;

    assign full     = (level_reg == (AW+1)'(DEPTH));
    assign empty    = (level_reg == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign level    = level_reg;
    assign pop_data = pop_data_reg;

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg] <= push_data;
        if (do_pop)  pop_data_reg <= mem[rd_ptr_reg];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level_reg <= level_reg + 1'b1;
                2'b01:   level_reg <= level_reg - 1'b1;
                default: level_reg <= level_reg;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// Multi-channel UART transmitter: round-robin arbiter into a shared FIFO, then a serialiser.
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int      NUM_CH     = 2,
    parameter int      DATA_WIDTH = 8,
    parameter parity_t PARITY     = PAR_NONE,
    parameter int      STOP_BITS  = 1,
    parameter int      FIFO_DEPTH = 16,
    parameter int      CLK_FREQ   = 100_000_000,
    parameter int      BAUD_RATE  = 115200
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_CH*DATA_WIDTH-1:0]    s_data,
    input  logic [NUM_CH-1:0]               s_valid,
    output logic [NUM_CH-1:0]               s_ready,
    output logic                            tx,
    output logic                            busy,
    output logic [$clog2(FIFO_DEPTH):0]     level
);
    localparam int PULSE_WIDTH = CLK_FREQ / BAUD_RATE;
    localparam int CNT_W       = $clog2(PULSE_WIDTH);
    localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [DATA_WIDTH-1:0] ch_data [NUM_CH];
    logic [DATA_WIDTH-1:0] push_data;
    logic [DATA_WIDTH-1:0] word;
    logic [CH_W-1:0]       ptr_reg, ptr_next, grant_idx;
    logic                  grant_any;
    logic                  fifo_full, fifo_empty, fifo_pop;

    state_t                state_reg, state_next;
    logic [CNT_W-1:0]      clk_cnt_reg, clk_cnt_next;
    logic [3:0]            bit_cnt_reg, bit_cnt_next;
    logic                  tx_reg, tx_next;
    logic                  bit_done;
    logic [15:0]           word_ext;
    logic                  par_bit;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
            assign ch_data[gi] = s_data[gi*DATA_WIDTH +: DATA_WIDTH];
            assign s_ready[gi] = grant_any && (grant_idx == CH_W'(gi));
        end
    endgenerate

    // First pass covers channels at or after the pointer, second pass wraps around.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = ptr_reg;
        push_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!grant_any && !fifo_full && s_valid[i] && (CH_W'(i) >= ptr_reg)) begin
                grant_any = 1'b1;
                grant_idx = CH_W'(i);
            end
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (!grant_any && !fifo_full && s_valid[i]) begin
                grant_any = 1'b1;
                grant_idx = CH_W'(i);
            end
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant_idx == CH_W'(i)) push_data = ch_data[i];
        end
        ptr_next = (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;
    end

    uart_sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (grant_any),
        .push_data (push_data),
        .pop       (fifo_pop),
        .pop_data  (word),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (level)
    );

    assign word_ext = 16'(word);
    assign par_bit  = parity_bit(MAX_DATA_WIDTH'(word), PARITY);
    assign bit_done = (clk_cnt_reg == CNT_W'(PULSE_WIDTH - 1));

    // tx is registered from the current state, so the line lags the FSM by one cycle.
    always_comb begin
        state_next   = state_reg;
        clk_cnt_next = bit_done ? '0 : clk_cnt_reg + 1'b1;
        bit_cnt_next = bit_cnt_reg;
        fifo_pop     = 1'b0;
        tx_next      = 1'b1;
        case (state_reg)
            ST_IDLE: begin
                clk_cnt_next = '0;
                bit_cnt_next = '0;
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    state_next = ST_START;
                end
            end
            ST_START: begin
                tx_next = 1'b0;
                if (bit_done) state_next = ST_DATA;
            end
            ST_DATA: begin
                tx_next = word_ext[bit_cnt_reg];
                if (bit_done) begin
                    if (bit_cnt_reg == 4'(DATA_WIDTH - 1)) begin
                        bit_cnt_next = '0;
                        state_next   = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                tx_next = par_bit;
                if (bit_done) state_next = ST_STOP;
            end
            ST_STOP: begin
                if (bit_done) begin
                    if (bit_cnt_reg == 4'(STOP_BITS - 1)) begin
                        bit_cnt_next = '0;
                        // Chain straight into the next start bit when a word is waiting.
                        if (!fifo_empty) begin
                            fifo_pop   = 1'b1;
                            state_next = ST_START;
                        end else begin
                            state_next = ST_IDLE;
                        end
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            clk_cnt_reg <= '0;
            bit_cnt_reg <= '0;
            tx_reg      <= 1'b1;
            ptr_reg     <= '0;
        end else begin
            state_reg   <= state_next;
            clk_cnt_reg <= clk_cnt_next;
            bit_cnt_reg <= bit_cnt_next;
            tx_reg      <= tx_next;
            if (grant_any) ptr_reg <= ptr_next;
        end
    end

    assign tx   = tx_reg;
    assign busy = (state_reg != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: queue-based line model on a 3-channel 8N1 instance plus literal frame checks.
module tb_uart_tx_arb;
    import uart_pkg::*;

    localparam int      PW      = 16;
    localparam int      CF      = 1_600_000;
    localparam int      BR      = 100_000;
    localparam int      M_NCH   = 3;
    localparam int      M_DEPTH = 4;
    localparam parity_t M_PAR   = PAR_NONE;
    localparam int      M_STOP  = 1;
    localparam int      M_FL    = PW * (1 + 8 + ((M_PAR != PAR_NONE) ? 1 : 0) + M_STOP);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [23:0] m_data;
    logic [2:0]  m_valid, m_ready;
    logic        m_tx, m_busy;
    logic [2:0]  m_level;

    logic [7:0]  e_data, o_data;
    logic [0:0]  e_valid, e_ready, o_valid, o_ready;
    logic        e_tx, e_busy, o_tx, o_busy;
    logic [1:0]  e_level, o_level;

    uart_tx_arb #(.NUM_CH(M_NCH), .DATA_WIDTH(8), .PARITY(M_PAR), .STOP_BITS(M_STOP),
                  .FIFO_DEPTH(M_DEPTH), .CLK_FREQ(CF), .BAUD_RATE(BR)) dut (
        .clk(clk), .rst(rst), .s_data(m_data), .s_valid(m_valid), .s_ready(m_ready),
        .tx(m_tx), .busy(m_busy), .level(m_level));

    uart_tx_arb #(.NUM_CH(1), .DATA_WIDTH(8), .PARITY(PAR_EVEN), .STOP_BITS(2),
                  .FIFO_DEPTH(2), .CLK_FREQ(CF), .BAUD_RATE(BR)) dut_e2 (
        .clk(clk), .rst(rst), .s_data(e_data), .s_valid(e_valid), .s_ready(e_ready),
        .tx(e_tx), .busy(e_busy), .level(e_level));

    uart_tx_arb #(.NUM_CH(1), .DATA_WIDTH(8), .PARITY(PAR_ODD), .STOP_BITS(1),
                  .FIFO_DEPTH(2), .CLK_FREQ(CF), .BAUD_RATE(BR)) dut_o1 (
        .clk(clk), .rst(rst), .s_data(o_data), .s_valid(o_valid), .s_ready(o_ready),
        .tx(o_tx), .busy(o_busy), .level(o_level));

    int n_pass = 0;
    int n_total = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_total++;
        if (act !== expv) $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        else n_pass++;
    endfunction

    // Model: words queued in order, each popped word becomes a list of per-cycle line values.
    logic [7:0] mq[$];
    logic       txq[$];
    int         dut_log[$];
    int         line_cnt = 0;
    int         m_ptr = 0;
    bit         model_ok = 1'b0;
    logic       exp_tx = 1'b1;
    int         exp_level = 0;
    bit         exp_busy = 1'b0;

    function automatic void push_bit(input logic b);
        for (int i = 0; i < PW; i++) txq.push_back(b);
    endfunction

    function automatic void add_frame(input logic [7:0] w);
        push_bit(1'b0);
        for (int i = 0; i < 8; i++) push_bit(w[i]);
        if (M_PAR != PAR_NONE) push_bit((^w) ^ (M_PAR == PAR_ODD));
        for (int s = 0; s < M_STOP; s++) push_bit(1'b1);
    endfunction

    always @(negedge clk) begin
        int g;
        int c;
        logic [2:0] gv;
        g = -1;
        if (mq.size() < M_DEPTH) begin
            for (int k = 0; k < M_NCH; k++) begin
                c = (m_ptr + k) % M_NCH;
                if (g < 0 && m_valid[c]) g = c;
            end
        end
        gv = (g >= 0) ? 3'(1 << g) : 3'b000;
        if (model_ok) begin
            chk("m_ready", m_ready, gv);
            chk("m_tx", m_tx, exp_tx);
            chk("m_level", m_level, exp_level);
            chk("m_busy", m_busy, exp_busy);
        end
        if (rst) begin
            mq.delete();
            txq.delete();
            line_cnt = 0;
            m_ptr    = 0;
            exp_tx   = 1'b1;
            model_ok = 1'b1;
        end else begin
            exp_tx = (txq.size() > 0) ? txq.pop_front() : 1'b1;
            if (line_cnt <= 1 && mq.size() > 0) begin
                add_frame(mq.pop_front());
                line_cnt = M_FL;
            end else if (line_cnt > 0) begin
                line_cnt--;
            end
            if (g >= 0) begin
                mq.push_back(m_data[g*8 +: 8]);
                m_ptr = (g + 1) % M_NCH;
            end
        end
        exp_level = mq.size();
        exp_busy  = (line_cnt > 0) || (mq.size() > 0);
    end

    always @(negedge clk) begin
        for (int i = 0; i < M_NCH; i++)
            if (!rst && m_valid[i] && m_ready[i]) dut_log.push_back(i);
    end

    function automatic int cur_tx(input int inst);
        return (inst == 0) ? int'(m_tx) : (inst == 1) ? int'(e_tx) : int'(o_tx);
    endfunction
    function automatic int cur_busy(input int inst);
        return (inst == 0) ? int'(m_busy) : (inst == 1) ? int'(e_busy) : int'(o_busy);
    endfunction
    function automatic int cur_level(input int inst);
        return (inst == 0) ? int'(m_level) : (inst == 1) ? int'(e_level) : int'(o_level);
    endfunction

    // Push one word on an idle instance and sample the line at every bit centre.
    task automatic frame_literal(input int inst, input logic [7:0] d, input int nbits,
                                 input logic [11:0] bits, input string nm);
        @(posedge clk); #1;
        case (inst)
            0:       begin m_data[7:0] = d; m_valid = 3'b001; end
            1:       begin e_data = d; e_valid = 1'b1; end
            default: begin o_data = d; o_valid = 1'b1; end
        endcase
        @(posedge clk); #1;
        m_valid = 3'b000; e_valid = 1'b0; o_valid = 1'b0;
        @(negedge clk); chk({nm, "_level1"}, cur_level(inst), 1);
        @(negedge clk); chk({nm, "_tx_before_start"}, cur_tx(inst), 1);
        @(negedge clk); chk({nm, "_start_edge"}, cur_tx(inst), 0);
        for (int k = 0; k < nbits; k++) begin
            repeat ((k == 0) ? 8 : 16) @(negedge clk);
            chk($sformatf("%s_bit%0d", nm, k), cur_tx(inst), bits[k]);
        end
        repeat (6) @(negedge clk);
        chk({nm, "_busy_last_cycle"}, cur_busy(inst), 1);
        @(negedge clk);
        chk({nm, "_busy_end"}, cur_busy(inst), 0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while (m_busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_idle_timeout"}, (n < 3000), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int rr_exp[6];
        rr_exp = '{0, 1, 2, 0, 1, 2};
        rst = 1'b1;
        m_data = '0; m_valid = '0;
        e_data = '0; e_valid = '0;
        o_data = '0; o_valid = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_tx", m_tx, 1);
        chk("rst_busy", m_busy, 0);
        chk("rst_level", m_level, 0);
        chk("rst_e2_tx", e_tx, 1);
        chk("rst_o1_tx", o_tx, 1);

        frame_literal(0, 8'hA5, 10, 12'b001101001010, "n1_a5");
        frame_literal(1, 8'h07, 12, 12'b111000001110, "e2_07");
        frame_literal(2, 8'h07, 11, 12'b010000001110, "o1_07");

        // All channels valid continuously: fills the FIFO, then one grant per pop.
        do_reset();
        dut_log.delete();
        m_data  = {8'h33, 8'h22, 8'h11};
        m_valid = 3'b111;
        repeat (40) @(posedge clk);
        @(negedge clk);
        chk("full_level", m_level, 4);
        chk("full_ready", m_ready, 3'b000);
        repeat (700) @(posedge clk);
        #1 m_valid = 3'b000;
        wait_idle("rr");
        chk("rr_count", (dut_log.size() >= 6), 1);
        if (dut_log.size() >= 6)
            for (int i = 0; i < 6; i++) chk($sformatf("rr_order%0d", i), dut_log[i], rr_exp[i]);

        // Simultaneous push and pop at level 1 and at level 2.
        do_reset();
        m_data[7:0] = 8'hC1; m_valid = 3'b001;
        @(posedge clk); #1 m_data[7:0] = 8'hC2;
        @(negedge clk); chk("pp_level_first", m_level, 1);
        @(posedge clk); #1 m_data[7:0] = 8'hC3;
        @(negedge clk); chk("pp_level_l1", m_level, 1);
        @(posedge clk); #1 m_valid = 3'b000;
        @(negedge clk); chk("pp_level_two", m_level, 2);
        repeat (158) @(posedge clk);
        #1 m_data[7:0] = 8'hC4; m_valid = 3'b001;
        @(negedge clk); chk("pp_level_before", m_level, 2);
        @(posedge clk); #1 m_valid = 3'b000;
        @(negedge clk); chk("pp_level_l2", m_level, 2);

        // Third queued word, then reset in the middle of a data bit.
        @(posedge clk); #1 m_data[7:0] = 8'hC5; m_valid = 3'b001;
        @(posedge clk); #1 m_valid = 3'b000;
        @(negedge clk); chk("mid_level3", m_level, 3);
        repeat (40) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_tx", m_tx, 1);
        chk("mid_rst_level", m_level, 0);
        chk("mid_rst_busy", m_busy, 0);
        frame_literal(0, 8'h3C, 10, 12'b001001111000, "post_rst_3c");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
